// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the ID/EX control bundle types used
// by the ALU issue stage.
package mips_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam int unsigned ALU_CTRL_W = 4;
  localparam int unsigned SHAMT_W    = 5;
  localparam int unsigned REG_W      = 5;

  typedef enum logic [1:0] {
    B_RT,
    B_SEXT,
    B_ZEXT,
    B_LUI
  } b_sel_e;

  typedef struct packed {
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic                  a_zero;
    b_sel_e                b_sel;
    logic                  shamt_en;
    logic                  rd_rt;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  branch;
    logic                  branch_ne;
    logic                  store_en;
    logic                  illegal;
  } dec_t;

  typedef struct packed {
    logic                  valid;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic [SHAMT_W-1:0]    shamt;
    logic [REG_W-1:0]      rd;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  branch;
    logic                  branch_ne;
    logic                  illegal;
  } ex_ctrl_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode/funct decode into ALU control, operand selects
// and pipeline control bits.
module alu_ctrl_decode
  import mips_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    dec          = '0;
    dec.alu_ctrl = ALU_ADD;
    dec.b_sel    = B_RT;
    unique case (op)
      OP_RTYPE: begin
        dec.reg_write = 1'b1;
        unique case (funct)
          FN_ADD, FN_ADDU: dec.alu_ctrl = ALU_ADD;
          FN_SUB, FN_SUBU: dec.alu_ctrl = ALU_SUB;
          FN_AND:          dec.alu_ctrl = ALU_AND;
          FN_OR:           dec.alu_ctrl = ALU_OR;
          FN_SLT:          dec.alu_ctrl = ALU_SLT;
          FN_SLL: begin
            dec.alu_ctrl = ALU_SLL;
            dec.shamt_en = 1'b1;
          end
          FN_SRL: begin
            dec.alu_ctrl = ALU_SRL;
            dec.shamt_en = 1'b1;
          end
          default: begin
            dec.reg_write = 1'b0;
            dec.illegal   = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        dec.rd_rt     = 1'b1;
        dec.b_sel     = B_SEXT;
        dec.reg_write = 1'b1;
      end
      OP_SLTI: begin
        dec.alu_ctrl  = ALU_SLT;
        dec.rd_rt     = 1'b1;
        dec.b_sel     = B_SEXT;
        dec.reg_write = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        dec.alu_ctrl  = (op == OP_ANDI) ? ALU_AND : ALU_OR;
        dec.rd_rt     = 1'b1;
        dec.b_sel     = B_ZEXT;
        dec.reg_write = 1'b1;
      end
      OP_LUI: begin
        dec.a_zero    = 1'b1;
        dec.rd_rt     = 1'b1;
        dec.b_sel     = B_LUI;
        dec.reg_write = 1'b1;
      end
      OP_LW: begin
        dec.rd_rt     = 1'b1;
        dec.b_sel     = B_SEXT;
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
      end
      OP_SW: begin
        dec.rd_rt     = 1'b1;
        dec.b_sel     = B_SEXT;
        dec.mem_write = 1'b1;
        dec.store_en  = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec.alu_ctrl  = ALU_SUB;
        dec.rd_rt     = 1'b1;
        dec.branch    = 1'b1;
        dec.branch_ne = (op == OP_BNE);
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX issue register for the ALU: decode, operand selection, stall/flush
// priority and issued-instruction counter.
module id_ex_alu_issue
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              id_ready,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_alu_a,
  output logic [DATA_W-1:0] ex_alu_b,
  output logic [4:0]        ex_shamt,
  output logic [3:0]        ex_alu_ctrl,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [4:0]        ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic              ex_branch_ne,
  output logic              ex_illegal,
  output logic [CNT_W-1:0]  ex_issue_count
);

  dec_t              dec;
  ex_ctrl_t          ctrl_d, ctrl_q;
  logic [DATA_W-1:0] a_d, a_q, b_d, b_q, st_d, st_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [4:0]        rd_sel;
  logic [15:0]       imm;
  logic              unused_rs_field;

  assign imm             = id_instr[15:0];
  assign unused_rs_field = ^id_instr[25:21];

  alu_ctrl_decode u_dec (
    .op    (id_instr[31:26]),
    .funct (id_instr[5:0]),
    .dec   (dec)
  );

  // Invalid ID and illegal decodes both leave the datapath fields zero;
  // only the valid/illegal/alu_ctrl bits distinguish an illegal issue.
  always_comb begin
    ctrl_d = '0;
    a_d    = '0;
    b_d    = '0;
    st_d   = '0;
    rd_sel = dec.rd_rt ? id_instr[20:16] : id_instr[15:11];
    if (id_valid) begin
      ctrl_d.valid    = 1'b1;
      ctrl_d.illegal  = dec.illegal;
      ctrl_d.alu_ctrl = dec.alu_ctrl;
      if (!dec.illegal) begin
        ctrl_d.rd        = rd_sel;
        ctrl_d.shamt     = dec.shamt_en ? id_instr[10:6] : '0;
        ctrl_d.reg_write = dec.reg_write && (rd_sel != '0);
        ctrl_d.mem_read  = dec.mem_read;
        ctrl_d.mem_write = dec.mem_write;
        ctrl_d.branch    = dec.branch;
        ctrl_d.branch_ne = dec.branch_ne;
        a_d              = dec.a_zero ? '0 : id_rs_data;
        st_d             = dec.store_en ? id_rt_data : '0;
        unique case (dec.b_sel)
          B_RT:    b_d = id_rt_data;
          B_SEXT:  b_d = DATA_W'(signed'(imm));
          B_ZEXT:  b_d = DATA_W'(imm);
          B_LUI:   b_d = DATA_W'({imm, 16'h0000});
          default: b_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      st_q   <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      ctrl_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      st_q   <= '0;
    end else if (!ex_stall) begin
      ctrl_q <= ctrl_d;
      a_q    <= a_d;
      b_q    <= b_d;
      st_q   <= st_d;
      if (id_valid) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign id_ready       = ~ex_stall;
  assign ex_valid       = ctrl_q.valid;
  assign ex_alu_a       = a_q;
  assign ex_alu_b       = b_q;
  assign ex_shamt       = ctrl_q.shamt;
  assign ex_alu_ctrl    = ctrl_q.alu_ctrl;
  assign ex_store_data  = st_q;
  assign ex_rd          = ctrl_q.rd;
  assign ex_reg_write   = ctrl_q.reg_write;
  assign ex_mem_read    = ctrl_q.mem_read;
  assign ex_mem_write   = ctrl_q.mem_write;
  assign ex_branch      = ctrl_q.branch;
  assign ex_branch_ne   = ctrl_q.branch_ne;
  assign ex_illegal     = ctrl_q.illegal;
  assign ex_issue_count = cnt_q;

endmodule

// File: doc/id_ex_alu_issue.md
Name: id_ex_alu_issue

Overview:
- Issue side of the ALU interface: decodes the MIPS instruction in ID into alu_ctrl, shamt and operand selection.
- Registers the decoded result into the ID/EX pipeline register that drives the combinational ALU during EX.
- Supports stall (hold), flush (bubble), illegal-opcode flagging and an issued-instruction counter.

Parameters:
DATA_W, 32, operand/result width
CNT_W, 32, width of issued-instruction counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
id_valid  in  1  ID holds a real instruction
id_instr  in  32  raw instruction word
id_rs_data  in  DATA_W  register-file read of rs
id_rt_data  in  DATA_W  register-file read of rt
ex_stall  in  1  hold EX register contents
flush  in  1  replace next EX contents with a bubble
id_ready  out  1  combinational; equals ~ex_stall
ex_valid  out  1  EX holds a real instruction
ex_alu_a  out  DATA_W  ALU operand a
ex_alu_b  out  DATA_W  ALU operand b
ex_shamt  out  5  ALU shift amount
ex_alu_ctrl  out  4  ALU opcode
ex_store_data  out  DATA_W  rt data for sw
ex_rd  out  5  destination register
ex_reg_write  out  1  writeback enable
ex_mem_read  out  1  load
ex_mem_write  out  1  store
ex_branch  out  1  beq/bne
ex_branch_ne  out  1  1 = bne
ex_illegal  out  1  unrecognised opcode/funct
ex_issue_count  out  CNT_W  count of valid instructions issued

Behaviour:
- Reset (rst_n low at posedge): all outputs/state 0, ex_valid=0; a bubble.
- Priority per posedge: reset > flush > ex_stall > load.
- flush=1: EX becomes a bubble: ex_valid=0, all controls 0, datapath outputs 0. This applies even when ex_stall=1.
- ex_stall=1 (no flush): every EX register holds its value; the counter holds.
- Load: EX latches the decode of id_instr; ex_valid=id_valid. Latency is 1 cycle from ID to ALU inputs.
  - If id_valid=0, a bubble is loaded, identical to the flush bubble.
- ALU encodings: AND=0000, OR=0001, ADD=0010, SLL=0011, SRL=0100, SUB=0110, SLT=0111.
- R-type (op 0x00):
  - funct add/addu 0x20/0x21 -> ADD; sub/subu 0x22/0x23 -> SUB; and 0x24 -> AND; or 0x25 -> OR; slt 0x2A -> SLT.
  - sll 0x00 -> SLL; srl 0x02 -> SRL.
  - a=rs_data, b=rt_data, shamt=instr[10:6], rd=instr[15:11], reg_write=1.
  - Shamt is passed through only for sll/srl and is 0 otherwise.
- I-type: rd=instr[20:16], b=immediate.
  - Sign-extended immediate: addi 0x08/addiu 0x09 -> ADD; slti 0x0A -> SLT.
  - Zero-extended immediate: andi 0x0C -> AND; ori 0x0D -> OR.
  - lui 0x0F: a=0, b={imm,16'h0}, ADD.
  - lw 0x23: ADD with sign-extended immediate, mem_read=1, reg_write=1.
  - sw 0x2B: ADD with sign-extended immediate, mem_write=1, reg_write=0, store_data=rt_data.
  - beq 0x04 / bne 0x05: SUB, a=rs, b=rt, branch=1, branch_ne=(op==0x05), reg_write=0.
- Destination register 0: reg_write is forced to 0 when the destination is 0 (sll $0,$0,0 NOP issues with reg_write=0).
- Illegal (any other op or R-type funct):
  - ex_valid=1, ex_illegal=1, alu_ctrl=ADD.
  - reg_write, mem_read, mem_write and branch all 0; datapath outputs 0.
- ex_issue_count: increments by 1 on every load with id_valid=1 (illegal included). It does not increment on a stall, flush or bubble load. Wraps from all-ones to 0.
- ex_illegal is 0 in every bubble.

Decomposition:
- Shared package mips_pkg:
  - ALU_AND/OR/ADD/SLL/SRL/SUB/SLT localparams.
  - Opcode and funct localparams.
  - EX control-bundle field widths.
- One sub-module, alu_ctrl_decode: purely combinational instr -> {alu_ctrl, imm/shamt select, ctrl bits, illegal}.
- This block adds the register, priority muxing and counter.

Test Plan:
- Reset: hold rst_n=0 two cycles with id_valid=1 -> all outputs 0, count 0. Release; add $3,$1,$2 with rs=10, rt=20 -> next cycle alu_ctrl=0010, a=10, b=20, rd=3, reg_write=1, count=1.
- sll $4,$5,4 with rt=1 -> alu_ctrl=0011, b=1, shamt=4. srl with shamt=2, rt=32 -> alu_ctrl=0100, shamt=2. slti imm=0xFFFF -> b=0xFFFFFFFF, alu_ctrl=0111. ori imm=0xFFFF -> b=0x0000FFFF.
- Stall: issue beq (rs=rt=10), then assert ex_stall 3 cycles while ID changes -> EX holds alu_ctrl=0110, branch=1, count unchanged, id_ready=0.
- Flush with ex_stall=1 simultaneously -> next cycle ex_valid=0, all controls 0. lw with rs=100, imm=-4 -> a=100, b=0xFFFFFFFC, mem_read=1.
- Illegal op 0x3F -> ex_valid=1, ex_illegal=1, reg_write=0, count increments. addi $0,$0,5 -> reg_write=0. Preload count to all-ones (256 issues at CNT_W=8) -> wraps to 0.
